// File: rtl/staff_tile_renderer.sv
// Ledger-line tile renderer: 32x8 map of 2-bit glyph codes, scan position -> glyph-ROM address,
// registered pixel_on three cycles after DrawX/DrawY are sampled. Includes a 256-cycle map clear sweep.
module staff_tile_renderer #(
    parameter int X0 = 64,
    parameter int Y0 = 160
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       wr_en,
    input  logic [4:0] wr_col,
    input  logic [2:0] wr_row,
    input  logic [1:0] wr_code,
    input  logic       clear_req,
    output logic       wr_ack,
    output logic       busy,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       pixel_on
);

    localparam logic [10:0] C_XLO = 11'(X0);
    localparam logic [10:0] C_XHI = 11'(X0 + 256);
    localparam logic [10:0] C_YLO = 11'(Y0);
    localparam logic [10:0] C_YHI = 11'(Y0 + 64);

    typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_idx;
    logic [7:0] w_next_idx;
    logic       w_sweep_wr;
    logic       w_wr_accept;

    logic [1:0] r_map [0:255];

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [7:0] w_dx;
    logic [5:0] w_dy;
    logic       w_in_region;

    logic       r_s1_in;
    logic [7:0] r_s1_idx;
    logic [2:0] r_s1_grow;
    logic [2:0] r_s1_gcol;
    logic [1:0] r_s2_code;
    logic [2:0] r_s2_grow;
    logic [2:0] r_s2_gcol;

    // Clear FSM state register; Reset parks it in SWEEP at index 0 so the map is always blanked.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_SWEEP;
            r_idx   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    // Clear FSM next state: clear_req only matters in IDLE, so a sweep is never restarted.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_next_state = ST_SWEEP;
                    w_next_idx   = 8'd0;
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_idx   = r_idx;
                end
            end
            ST_SWEEP: begin
                w_next_idx = r_idx + 8'd1;
                if (r_idx == 8'd255) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SWEEP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_idx   = 8'd0;
            end
        endcase
    end

    // Clear FSM outputs and write-port arbitration.
    always_comb begin
        busy        = (r_state == ST_SWEEP);
        w_sweep_wr  = busy && !Reset;
        w_wr_accept = wr_en && !busy && !clear_req && !Reset;
    end

    // Tile-map write port; the sweep and host writes are mutually exclusive via busy.
    always_ff @(posedge Clk) begin
        if (w_sweep_wr) begin
            r_map[r_idx] <= 2'd0;
        end else if (w_wr_accept) begin
            r_map[{wr_row, wr_col}] <= wr_code;
        end
    end

    // Write acknowledge pulse, one cycle after the accepting edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= w_wr_accept;
        end
    end

    assign w_dx        = 8'(r_x - 10'(X0));
    assign w_dy        = 6'(r_y - 10'(Y0));
    assign w_in_region = ({1'b0, r_x} >= C_XLO) && ({1'b0, r_x} < C_XHI) &&
                         ({1'b0, r_y} >= C_YLO) && ({1'b0, r_y} < C_YHI);

    // Render pipeline: scan sample, S1 tile decode, S2 map read (old value on same-entry write), pixel out.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x       <= 10'd0;
            r_y       <= 10'd0;
            r_s1_in   <= 1'b0;
            r_s1_idx  <= 8'd0;
            r_s1_grow <= 3'd0;
            r_s1_gcol <= 3'd0;
            r_s2_code <= 2'd0;
            r_s2_grow <= 3'd0;
            r_s2_gcol <= 3'd0;
            pixel_on  <= 1'b0;
        end else begin
            r_x       <= DrawX;
            r_y       <= DrawY;
            r_s1_in   <= w_in_region;
            r_s1_idx  <= {w_dy[5:3], w_dx[7:3]};
            r_s1_grow <= w_dy[2:0];
            r_s1_gcol <= w_dx[2:0];
            r_s2_code <= r_s1_in ? r_map[r_s1_idx] : 2'd0;
            r_s2_grow <= r_s1_grow;
            r_s2_gcol <= r_s1_gcol;
            pixel_on  <= rom_data[3'd7 - r_s2_gcol];
        end
    end

    assign rom_addr = {r_s2_code, r_s2_grow};

endmodule

// File: tb/tb_staff_tile_renderer.sv
// Self-checking bench for staff_tile_renderer: table-driven glyph vectors, clear/reset sequences,
// and randomized map/scan traffic checked against an arithmetic reference model.
module tb_staff_tile_renderer;

    localparam int X0 = 64;
    localparam int Y0 = 160;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_col = 5'd0;
    logic [2:0] wr_row = 3'd0;
    logic [1:0] wr_code = 2'd0;
    logic       clear_req = 1'b0;
    logic       wr_ack;
    logic       busy;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic       pixel_on;
    bit         rom_pattern = 1'b0;

    staff_tile_renderer #(.X0(X0), .Y0(Y0)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_code(wr_code),
        .clear_req(clear_req), .wr_ack(wr_ack), .busy(busy),
        .rom_addr(rom_addr), .rom_data(rom_data), .pixel_on(pixel_on)
    );

    always #5 Clk = ~Clk;

    // Ledger-line glyph ROM; pattern mode gives every row a distinct bit pattern.
    function automatic logic [7:0] rom_fn(input logic [1:0] code, input logic [2:0] gy, input bit pat);
        int a;
        a = int'(code) * 8 + int'(gy);
        if (code == 2'd0) return 8'h00;
        if (pat) return 8'((a * 29 + 7) % 256);
        if ((code == 2'd1 && gy == 3'd4) || (code == 2'd2 && gy == 3'd0) || (code == 2'd3 && gy == 3'd7))
            return 8'hFF;
        return 8'h00;
    endfunction

    always_comb rom_data = rom_fn(rom_addr[4:3], rom_addr[2:0], rom_pattern);

    typedef struct {
        logic       pix;
        logic [1:0] hi;
        logic [2:0] lo;
        bit         lo_chk;
        int         x;
        int         y;
        int         stamp;
    } exp_t;

    typedef struct {
        int         x;
        int         y;
        logic       pix;
        logic [1:0] hi;
        logic [2:0] lo;
        bit         lo_chk;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    exp_t       q[$];
    logic [1:0] model[256];
    vec_t       tbl[16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Reference: region test and tile lookup by plain division on pixel coordinates.
    function automatic exp_t ref_px(input int x, input int y);
        exp_t e;
        int   dx, dy;
        logic [7:0] row_bits;
        dx = x - X0;
        dy = y - Y0;
        e.x = x; e.y = y; e.stamp = 0;
        if (dx >= 0 && dx < 256 && dy >= 0 && dy < 64) begin
            e.hi     = model[(dy / 8) * 32 + dx / 8];
            e.lo     = 3'(dy % 8);
            e.lo_chk = 1'b1;
            row_bits = rom_fn(e.hi, e.lo, rom_pattern);
            e.pix    = row_bits[7 - (dx % 8)];
        end else begin
            e.hi = 2'd0; e.lo = 3'd0; e.lo_chk = 1'b0; e.pix = 1'b0;
        end
        return e;
    endfunction

    task automatic tick(input bit push, input exp_t e);
        exp_t h;
        @(negedge Clk);
        cyc++;
        while (q.size() > 0 && q[0].stamp <= cyc - 4) begin
            h = q.pop_front();
            chk($sformatf("pixel_on x=%0d y=%0d", h.x, h.y), {7'd0, pixel_on}, {7'd0, h.pix});
        end
        if (q.size() > 0 && q[0].stamp == cyc - 3) begin
            chk($sformatf("rom_addr_code x=%0d y=%0d", q[0].x, q[0].y), {6'd0, rom_addr[4:3]}, {6'd0, q[0].hi});
            if (q[0].lo_chk)
                chk($sformatf("rom_addr_row x=%0d y=%0d", q[0].x, q[0].y), {5'd0, rom_addr[2:0]}, {5'd0, q[0].lo});
        end
        if (push) begin
            DrawX = 10'(e.x);
            DrawY = 10'(e.y);
            e.stamp = cyc;
            q.push_back(e);
        end
    endtask

    task automatic issue_ref(input int x, input int y);
        tick(1'b1, ref_px(x, y));
    endtask

    task automatic drain();
        exp_t d;
        d = ref_px(0, 0);
        repeat (4) tick(1'b0, d);
    endtask

    task automatic do_write(input int col, input int row, input int code, input bit exp_ack);
        @(negedge Clk);
        wr_en = 1'b1; wr_col = 5'(col); wr_row = 3'(row); wr_code = 2'(code);
        @(negedge Clk);
        wr_en = 1'b0;
        chk($sformatf("wr_ack c%0d r%0d", col, row), {7'd0, wr_ack}, {7'd0, exp_ack});
        if (exp_ack) model[row * 32 + col] = 2'(code);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic readback_all(input string tag);
        for (int t = 0; t < 256; t++) begin
            exp_t e;
            e = ref_px(X0 + (t % 32) * 8, Y0 + (t / 32) * 8);
            e.hi = 2'd0;
            tick(1'b1, e);
        end
        drain();
    endtask

    initial begin
        int   n;
        logic saw_pix;
        exp_t e;

        for (int i = 0; i < 256; i++) model[i] = 2'd0;
        for (int i = 0; i < 8; i++) tbl[2 + i] = '{X0 + i, Y0, 1'b1, 2'd2, 3'd0, 1'b1};
        tbl[0]  = '{X0 + 29,  Y0 + 20, 1'b1, 2'd1, 3'd4, 1'b1};
        tbl[1]  = '{X0 + 29,  Y0 + 19, 1'b0, 2'd1, 3'd3, 1'b1};
        tbl[10] = '{X0 + 8,   Y0,      1'b0, 2'd0, 3'd0, 1'b1};
        tbl[11] = '{X0 + 255, Y0 + 63, 1'b1, 2'd3, 3'd7, 1'b1};
        tbl[12] = '{X0 + 256, Y0 + 63, 1'b0, 2'd0, 3'd0, 1'b0};
        tbl[13] = '{X0 - 1,   Y0 + 63, 1'b0, 2'd0, 3'd0, 1'b0};
        tbl[14] = '{X0 + 7,   Y0 + 64, 1'b0, 2'd0, 3'd0, 1'b0};
        tbl[15] = '{X0 + 255, Y0 + 62, 1'b0, 2'd3, 3'd6, 1'b1};

        // Reset sweep
        DrawX = 10'(X0 + 3); DrawY = 10'(Y0 + 4);
        repeat (2) @(negedge Clk);
        chk("reset_busy", {7'd0, busy}, 8'd1);
        chk("reset_wr_ack", {7'd0, wr_ack}, 8'd0);
        chk("reset_pixel_on", {7'd0, pixel_on}, 8'd0);
        chk("reset_rom_addr", {3'd0, rom_addr}, 8'd0);
        Reset = 1'b0;
        saw_pix = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge Clk);
            saw_pix = saw_pix | pixel_on;
        end
        chk("reset_sweep_len", 8'(n), 8'(256));
        chk("pixel_during_sweep", {7'd0, saw_pix}, 8'd0);
        readback_all("post_reset");

        // Glyph placement and region boundaries from the vector table
        do_write(3, 2, 1, 1'b1);
        do_write(0, 0, 2, 1'b1);
        do_write(31, 7, 3, 1'b1);
        for (int i = 0; i < 16; i++) begin
            e = '{tbl[i].pix, tbl[i].hi, tbl[i].lo, tbl[i].lo_chk, tbl[i].x, tbl[i].y, 0};
            tick(1'b1, e);
        end
        drain();

        // Out-of-region with a full map
        for (int t = 0; t < 256; t++) do_write(t % 32, t / 32, 1, 1'b1);
        issue_ref(X0 - 1, Y0 + 4);
        issue_ref(X0 + 4, Y0 + 64);
        issue_ref(X0 + 4, Y0 + 4);
        issue_ref(X0 + 256, Y0 + 12);
        drain();

        // Clear with a dropped follow-up write and a second clear_req at index 100
        do_write(5, 5, 2, 1'b1);
        @(negedge Clk);
        clear_req = 1'b1;
        @(negedge Clk);
        clear_req = 1'b0;
        wr_en = 1'b1; wr_col = 5'd6; wr_row = 3'd6; wr_code = 2'd1;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge Clk);
            if (n == 1) begin
                wr_en = 1'b0;
                chk("dropped_wr_ack", {7'd0, wr_ack}, 8'd0);
            end
            if (n == 100) clear_req = 1'b1;
            if (n == 101) clear_req = 1'b0;
        end
        chk("clear_sweep_len", 8'(n), 8'(256));
        for (int i = 0; i < 256; i++) model[i] = 2'd0;
        readback_all("post_clear");

        // Write in the same cycle as clear_req is dropped
        @(negedge Clk);
        clear_req = 1'b1; wr_en = 1'b1; wr_col = 5'd7; wr_row = 3'd1; wr_code = 2'd3;
        @(negedge Clk);
        clear_req = 1'b0; wr_en = 1'b0;
        chk("same_cycle_wr_ack", {7'd0, wr_ack}, 8'd0);
        count_busy(n);
        chk("clear2_sweep_len", 8'(n), 8'(256));

        // Reset at sweep index 128 restarts the sweep
        do_write(10, 4, 3, 1'b1);
        @(negedge Clk);
        clear_req = 1'b1;
        @(negedge Clk);
        clear_req = 1'b0;
        repeat (128) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midreset_busy", {7'd0, busy}, 8'd1);
        chk("midreset_pixel_on", {7'd0, pixel_on}, 8'd0);
        chk("midreset_rom_addr", {3'd0, rom_addr}, 8'd0);
        count_busy(n);
        chk("midreset_sweep_len", 8'(n), 8'(256));
        for (int i = 0; i < 256; i++) model[i] = 2'd0;
        issue_ref(X0 + 80, Y0 + 32);
        drain();

        // Randomized map contents and scan positions in pattern-ROM mode
        rom_pattern = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 80; w++)
                do_write(int'($urandom_range(31, 0)), int'($urandom_range(7, 0)), int'($urandom_range(3, 0)), 1'b1);
            for (int p = 0; p < 200; p++)
                issue_ref(int'($urandom_range(X0 + 271, X0 - 16)), int'($urandom_range(Y0 + 71, Y0 - 8)));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/staff_tile_renderer.md
# staff_tile_renderer

Per-pixel renderer for the ledger-line layer of the staff display. It holds a 32×8 map of 2-bit glyph codes, written by the note sequencer. It converts the VGA scan position into a glyph-ROM address of the form {code, glyph row}, takes the returned 8-bit glyph row, and emits a registered `pixel_on` bit to the colour mapper. It sits between the VGA controller/sequencer and the colour mapper, and drives the ledger-line glyph ROM directly.

## Interface
Parameters:
- `X0`, 64, left pixel edge of the staff region. Constraint: X0 + 256 ≤ 1024.
- `Y0`, 160, top pixel edge of the staff region. Constraint: Y0 + 64 ≤ 1024.

Ports:
- `Clk`  in  1  system clock. One clock only; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `DrawX`  in  10  current scan column.
- `DrawY`  in  10  current scan row.
- `wr_en`  in  1  tile-map write request, one cycle per write.
- `wr_col`  in  5  tile column, 0..31.
- `wr_row`  in  3  tile row, 0..7.
- `wr_code`  in  2  glyph code. 0 = blank, 1 = middle line, 2 = line above, 3 = line below.
- `clear_req`  in  1  pulse; clears the whole map to code 0.
- `wr_ack`  out  1  one-cycle pulse confirming an accepted write.
- `busy`  out  1  clear sweep in progress.
- `rom_addr`  out  5  glyph-ROM address, {code[1:0], glyph_row[2:0]}.
- `rom_data`  in  8  glyph-ROM row data, asynchronous (same-cycle) read. Bit 7 is the leftmost pixel.
- `pixel_on`  out  1  ledger-line pixel at the scan position sampled 3 cycles earlier.

## Operation
- **Tile map:** 256 × 2 bits, index {wr_row, wr_col}.
  - Separate write port and registered read port.
  - When a write and a read hit the same entry in the same cycle, the read returns the old value.
- **Region test:** in_region = (X0 ≤ DrawX < X0+256) && (Y0 ≤ DrawY < Y0+64).
  - dx = DrawX − X0; dy = DrawY − Y0. Both are 10-bit unsigned and are only meaningful when in_region.
  - tile_col = dx[7:3], tile_row = dy[5:3], glyph_row = dy[2:0], glyph_col = dx[2:0].
- **Pipeline:**
  - S1 registers: in_region, tile index, glyph_row, glyph_col.
  - S2 registers: map read result (forced to 0 when !in_region), glyph_row, glyph_col.
  - `rom_addr` = {S2.code, S2.glyph_row}, combinational from S2 registers.
  - Output stage: `pixel_on` <= rom_data[7 − S2.glyph_col].
- **Write handshake:**
  - A write is accepted when wr_en && !busy && !clear_req. The entry is updated at that edge, and `wr_ack` = 1 for the following cycle.
  - wr_en while busy, or in the same cycle as clear_req, is dropped with no ack. The requester must retry.
- **Clear FSM:** states IDLE and SWEEP.
  - IDLE → SWEEP on clear_req: sweep index = 0, busy = 1.
  - In SWEEP, the entry at the sweep index is written with 0 each cycle, then the index increments.
  - After entry 255 is written: → IDLE, busy = 0 in the next cycle. The sweep takes exactly 256 write cycles.
  - clear_req during SWEEP is ignored; the sweep does not restart.
- **Reset:**
  - While Reset is high: FSM = SWEEP, index = 0, busy = 1, wr_ack = 0, all pipeline registers = 0, so pixel_on = 0 and rom_addr = 0.
  - After Reset drops, the sweep runs 256 cycles, so the map is always all-blank after reset.
  - Reset mid-sweep restarts the sweep at index 0.
- Rendering continues during SWEEP. Reads return the current contents, which may be partially cleared.

## Timing
- **Latency:** DrawX/DrawY sampled at edge N; pixel_on valid after edge N+3. Fully pipelined, one pixel per cycle.
- **rom_addr:** reflects the sample from edge N during the cycle after edge N+2. rom_data must settle within that same cycle.
- **Write to render:** a write accepted at edge W is visible to a read sampled into S1 at edge W or later, landing in S2 at edge W+1 or later.
- **busy:** rises the cycle after clear_req (or immediately under Reset) and stays high for 256 cycles after the sweep starts.
- **Boundaries:**
  - DrawX = X0+255 is in-region; X0+256 is out.
  - DrawY = Y0+63 is in-region; Y0+64 is out.
  - DrawX < X0 does not wrap: unsigned compare only.

## Test plan
- **Reset sweep:** Reset 2 cycles then release → busy = 1 for 256 cycles then 0; pixel_on = 0 throughout; all 256 entries read back as 0.
- **Middle line:** write col 3, row 2, code 1, wait for wr_ack. Then:
  - DrawX = X0+29, DrawY = Y0+20 → pixel_on = 1 three cycles later, and rom_addr = 5'b01100 in the cycle before.
  - DrawY = Y0+19 → pixel_on = 0.
- **Above/below glyphs:**
  - Code 2 at col 0, row 0: DrawY = Y0 → pixel_on = 1 for DrawX = X0..X0+7.
  - Code 3 at col 31, row 7: DrawX = X0+255, DrawY = Y0+63 → pixel_on = 1.
  - Same code-3 tile at DrawX = X0+256 → pixel_on = 0.
- **Out-of-region:** map filled with code 1; DrawX = X0−1, or DrawY = Y0+64 → rom_addr[4:3] = 0 and pixel_on = 0.
- **Clear and dropped writes:**
  - clear_req, then wr_en on the next cycle → no wr_ack, entry stays 0.
  - Second clear_req at sweep index 100 → busy still falls exactly 256 cycles after the first.
- **Reset mid-sweep:** Reset at sweep index 128 → busy stays high for a further full 256 cycles after release; the entry written before the clear reads back 0.
